// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2c_pkg                                                |
// | Description : Shared types, constants and the per-phase line-level   |
// |               table for the I2C bit controller.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_STOP  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_READ  = 2'b11
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        PH_P0 = 3'd0,
        PH_P1 = 3'd1,
        PH_P2 = 3'd2,
        PH_P3 = 3'd3,
        PH_P4 = 3'd4
    } i2c_phase_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } i2c_state_e;

    // Smallest usable prescale: the 2-FF synchronizer must see a released
    // SCL before the terminal count of a high phase, otherwise every high
    // phase would look like a stretch.
    localparam int unsigned I2C_MIN_PRESCALE = 3;

    // Released line levels {scl, sda} for a command in a given phase.
    // A level of 1 means the line is released (pulled up), 0 means driven low.
    function automatic logic [1:0] i2c_levels(i2c_cmd_e cmd, i2c_phase_e ph, logic d);
        logic scl;
        logic sda;
        scl = 1'b1;
        sda = 1'b1;
        case (cmd)
            CMD_START: begin
                scl = (ph != PH_P4);
                sda = (ph == PH_P0) || (ph == PH_P1);
            end
            CMD_STOP: begin
                scl = (ph != PH_P0);
                sda = (ph == PH_P3) || (ph == PH_P4);
            end
            CMD_WRITE: begin
                scl = (ph != PH_P0) && (ph != PH_P4);
                sda = d;
            end
            default: begin
                scl = (ph != PH_P0) && (ph != PH_P4);
                sda = 1'b1;
            end
        endcase
        return {scl, sda};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bit_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2c_bit_controller_if                                  |
// | Description : Command handshake and bus-line bundle for the I2C bit  |
// |               controller.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface i2c_bit_controller_if #(
    parameter int FREQ_SELECTION_BIT_WIDTH = 16
);
    logic [FREQ_SELECTION_BIT_WIDTH-1:0] frequency_setting_i;
    logic                                cmd_valid_i;
    logic                                cmd_ready_o;
    logic [1:0]                          cmd_i;
    logic                                cmd_data_i;
    logic                                done_o;
    logic                                rx_bit_o;
    logic                                arb_lost_o;
    logic                                busy_o;
    logic                                scl_i;
    logic                                sda_i;
    logic                                scl_oe_o;
    logic                                sda_oe_o;

    // Engine side
    modport slave (
        input  frequency_setting_i, cmd_valid_i, cmd_i, cmd_data_i, scl_i, sda_i,
        output cmd_ready_o, done_o, rx_bit_o, arb_lost_o, busy_o, scl_oe_o, sda_oe_o
    );

    // Byte-controller side
    modport master (
        output frequency_setting_i, cmd_valid_i, cmd_i, cmd_data_i, scl_i, sda_i,
        input  cmd_ready_o, done_o, rx_bit_o, arb_lost_o, busy_o, scl_oe_o, sda_oe_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_input_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2c_input_sync                                         |
// | Description : Two-flop synchronizer for an asynchronous bus line.    |
// |               Resets to 1 (idle bus level).                          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2c_input_sync (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_async,
    output logic      o_sync
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;
endmodule
`default_nettype wire

// File: rtl/i2c_bit_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : i2c_bit_controller                                     |
// | Description : I2C bit engine. Executes START/STOP/WRITE/READ as five |
// |               equal phases of (N+1) clocks with clock stretching and |
// |               arbitration-loss detection.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module i2c_bit_controller
    import i2c_pkg::*;
#(
    parameter int FREQ_SELECTION_BIT_WIDTH = 16
) (
    input  wire logic             wb_clk_i,
    input  wire logic             wb_rst_n_i,
    i2c_bit_controller_if.slave   bus
);
    localparam int W = FREQ_SELECTION_BIT_WIDTH;
    localparam logic [W-1:0] MIN_N = W'(I2C_MIN_PRESCALE);
    localparam logic [W-1:0] ONE   = W'(1);

    i2c_state_e state_q, state_d;
    i2c_phase_e phase_q, phase_d;
    i2c_cmd_e   cmd_q, cmd_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_q, n_d;
    logic data_q, data_d;
    logic scl_oe_q, scl_oe_d;
    logic sda_oe_q, sda_oe_d;
    logic rx_cap_q, rx_cap_d;
    logic rx_bit_q, rx_bit_d;
    logic arb_q, arb_d;

    logic       w_scl_sync;
    logic       w_sda_sync;
    logic       w_accept;
    logic       w_terminal;
    logic       w_arb_phase;
    logic [1:0] w_cur_lvl;
    logic [1:0] w_nxt_lvl;
    logic [1:0] w_new_lvl;

    i2c_input_sync u_scl_sync (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .i_async (bus.scl_i),
        .o_sync  (w_scl_sync)
    );

    i2c_input_sync u_sda_sync (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .i_async (bus.sda_i),
        .o_sync  (w_sda_sync)
    );

    assign w_accept   = bus.cmd_valid_i && (state_q != ST_RUN);
    assign w_terminal = (cnt_q == n_q);
    assign w_cur_lvl  = i2c_levels(cmd_q, phase_q, data_q);
    assign w_nxt_lvl  = i2c_levels(cmd_q, i2c_phase_e'(phase_q + 3'd1), data_q);
    assign w_new_lvl  = i2c_levels(i2c_cmd_e'(bus.cmd_i), PH_P0, bus.cmd_data_i);

    // Phases where we release SDA and expect it to stay high while SCL is high
    assign w_arb_phase = ((cmd_q == CMD_WRITE) && data_q &&
                          ((phase_q == PH_P1) || (phase_q == PH_P2) || (phase_q == PH_P3))) ||
                         ((cmd_q == CMD_START) &&
                          ((phase_q == PH_P0) || (phase_q == PH_P1)));

    // Next-state, phase counter and line-drive decisions
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        data_d   = data_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        rx_cap_d = rx_cap_q;
        rx_bit_d = rx_bit_q;
        arb_d    = arb_q;

        case (state_q)
            ST_RUN: begin
                if (!w_terminal) begin
                    cnt_d = cnt_q + ONE;
                end else if (w_cur_lvl[1] && !w_scl_sync) begin
                    // A slave is stretching SCL: hold at the terminal count
                    cnt_d = cnt_q;
                end else if (w_arb_phase && w_cur_lvl[1] && w_cur_lvl[0] && !w_sda_sync) begin
                    state_d  = ST_DONE;
                    scl_oe_d = 1'b0;
                    sda_oe_d = 1'b0;
                    arb_d    = 1'b1;
                end else if (phase_q == PH_P4) begin
                    state_d = ST_DONE;
                    if (cmd_q == CMD_READ) begin
                        rx_bit_d = rx_cap_q;
                    end
                end else begin
                    if (phase_q == PH_P2) begin
                        rx_cap_d = w_sda_sync;
                    end
                    phase_d  = i2c_phase_e'(phase_q + 3'd1);
                    cnt_d    = '0;
                    scl_oe_d = !w_nxt_lvl[1];
                    sda_oe_d = !w_nxt_lvl[0];
                end
            end
            default: begin
                // Idle and done behave alike: a command may start immediately
                if (w_accept) begin
                    state_d  = ST_RUN;
                    phase_d  = PH_P0;
                    cnt_d    = '0;
                    cmd_d    = i2c_cmd_e'(bus.cmd_i);
                    data_d   = bus.cmd_data_i;
                    n_d      = (bus.frequency_setting_i < MIN_N) ? MIN_N : bus.frequency_setting_i;
                    arb_d    = 1'b0;
                    scl_oe_d = !w_new_lvl[1];
                    sda_oe_d = !w_new_lvl[0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State, counter and output registers; reset releases both lines at once
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_P0;
            cmd_q    <= CMD_START;
            cnt_q    <= '0;
            n_q      <= MIN_N;
            data_q   <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            rx_cap_q <= 1'b0;
            rx_bit_q <= 1'b0;
            arb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cmd_q    <= cmd_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            data_q   <= data_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            rx_cap_q <= rx_cap_d;
            rx_bit_q <= rx_bit_d;
            arb_q    <= arb_d;
        end
    end

    assign bus.cmd_ready_o = (state_q != ST_RUN);
    assign bus.busy_o      = (state_q == ST_RUN);
    assign bus.done_o      = (state_q == ST_DONE);
    assign bus.rx_bit_o    = rx_bit_q;
    assign bus.arb_lost_o  = arb_q;
    assign bus.scl_oe_o    = scl_oe_q;
    assign bus.sda_oe_o    = sda_oe_q;
endmodule
`default_nettype wire
